mac_match_ctrl: RTL

Frame-level sequencer for the sniffer's `mac_comparator`. It sits between the packet word stream and the comparator and does four jobs:
- holds the flagged MAC configuration and applies it only at frame boundaries;
- issues the per-frame comparator clear;
- feeds frame words into the comparator and zero-fills the pipeline drain;
- realigns the delayed output stream and returns a single per-frame match verdict through a valid/ready handshake.

---
 rtl/mac_match_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mac_match_ctrl.sv
// Frame sequencer in front of mac_comparator. It applies MAC config at frame boundaries,
// clears the comparator, feeds gapless words, zero-fills the drain and reports one verdict per frame.
//
//   state  | meaning
//   IDLE   | wait for frame_start; active MAC follows pending MAC
//   CLEAR  | one-cycle comparator clear, frame counters zeroed
//   STREAM | accept gapless words into the comparator
//   DRAIN  | zero-fill PIPE_LAT+1 cycles to flush the comparator pipeline
//   REPORT | verdict held until verdict_ready
module mac_match_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MAC_W    = 48,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAC_W-1:0]  cfg_mac,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              cmp_clear,
  output logic [MAC_W-1:0]  cmp_flagged_mac,
  output logic [DATA_W-1:0] cmp_data_in,
  input  logic [DATA_W-1:0] cmp_data_out,
  input  logic              cmp_match,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              verdict_valid,
  output logic              verdict_match,
  output logic              verdict_err,
  output logic [CNT_W-1:0]  verdict_words,
  input  logic              verdict_ready,
  output logic              busy
);

  localparam int DRN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(PIPE_LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [MAC_W-1:0]    pending_mac;
  logic [MAC_W-1:0]    active_mac;
  logic [CNT_W-1:0]    word_cnt;
  logic                sticky;
  logic                err;
  logic [DRN_W-1:0]    drain_cnt;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [PIPE_LAT-1:0] last_sr;
  logic                accept;
  logic                in_report;

  assign accept    = (state == STREAM) && in_valid;
  assign in_report = (state == REPORT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (!in_valid || in_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = REPORT;
      REPORT:  if (verdict_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_mac <= '0;
      active_mac  <= '0;
      word_cnt    <= '0;
      sticky      <= 1'b0;
      err         <= 1'b0;
      drain_cnt   <= '0;
      vld_sr      <= '0;
      last_sr     <= '0;
    end else begin
      if (cfg_we) pending_mac <= cfg_mac;
      // Copy happens before this cycle's cfg_we lands, so a write alongside frame_start waits a frame.
      if (state == IDLE) active_mac <= pending_mac;

      case (state)
        CLEAR: begin
          word_cnt <= '0;
          sticky   <= 1'b0;
          err      <= 1'b0;
        end
        STREAM: begin
          if (accept && (word_cnt != {CNT_W{1'b1}})) word_cnt <= word_cnt + CNT_W'(1);
          if (!in_valid) err <= 1'b1;
          sticky    <= sticky | cmp_match;
          drain_cnt <= DRAIN_LOAD;
        end
        DRAIN: begin
          sticky <= sticky | cmp_match;
          if (drain_cnt != '0) drain_cnt <= drain_cnt - DRN_W'(1);
        end
        default: ;
      endcase

      vld_sr[0]  <= accept;
      last_sr[0] <= accept && in_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign in_ready        = (state == STREAM);
  assign cmp_clear       = rst || (state == CLEAR);
  assign cmp_flagged_mac = active_mac;
  assign cmp_data_in     = accept ? in_data : '0;

  assign out_valid = vld_sr[PIPE_LAT-1];
  assign out_last  = last_sr[PIPE_LAT-1];
  assign out_data  = cmp_data_out;

  assign verdict_valid = in_report;
  assign verdict_match = in_report && sticky && !err;
  assign verdict_err   = in_report && err;
  assign verdict_words = in_report ? word_cnt : '0;
  assign busy          = (state != IDLE);

endmodule
